// File: rtl/token_decimate_scheduler_pkg.sv
// Shared constants and types for the token decimate scheduler.
package token_sched_pkg;

    localparam int unsigned N_CH_DEFAULT    = 4;
    localparam int unsigned RATIO_W_DEFAULT = 4;
    localparam int unsigned RATIO_DEFAULT   = 2;

    typedef logic [$clog2(N_CH_DEFAULT)-1:0] ch_idx_t;
    typedef logic [RATIO_W_DEFAULT-1:0]      ratio_t;

endpackage

// File: rtl/token_decimate_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first request at or after i_ptr, wrapping.
module rr_arbiter #(
    parameter  int unsigned N_CH = 4,
    localparam int unsigned CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] i_req,
    input  logic [CH_W-1:0] i_ptr,
    output logic [CH_W-1:0] o_grant,
    output logic            o_any
);

    int unsigned w_idx;

    always_comb begin
        o_grant = '0;
        o_any   = 1'b0;
        w_idx   = 0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            w_idx = (32'(i_ptr) + k) % N_CH;
            if (!o_any && i_req[CH_W'(w_idx)]) begin
                o_grant = CH_W'(w_idx);
                o_any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/token_decimate_scheduler.sv
// Per-channel token decimators feeding a round-robin drained, registered
// valid/ready output; runtime ratio configuration through a write port.
module token_decimate_scheduler
    import token_sched_pkg::*;
#(
    parameter  int unsigned N_CH    = N_CH_DEFAULT,
    parameter  int unsigned RATIO_W = RATIO_W_DEFAULT,
    localparam int unsigned CH_W    = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_CH-1:0]    tok_in,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [RATIO_W-1:0] cfg_ratio,
    output logic               out_valid,
    output logic [CH_W-1:0]    out_ch,
    input  logic               out_ready,
    output logic [N_CH-1:0]    ovf
);

    logic [N_CH-1:0] w_pend;
    logic [N_CH-1:0] w_pass;
    logic [N_CH-1:0] w_grant_vec;
    logic [CH_W-1:0] w_grant;
    logic [CH_W-1:0] r_ptr;
    logic            w_any;
    logic            w_slot_free;
    logic            w_cfg_valid;

    assign w_slot_free = !out_valid || out_ready;
    assign w_cfg_valid = cfg_we && (32'(cfg_ch) < N_CH);

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .i_req   (w_pend),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_any   (w_any)
    );

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [RATIO_W-1:0] r_ratio;
        logic [RATIO_W-1:0] r_cnt;
        logic               r_pend;
        logic               r_ovf;
        logic               w_cfg_hit;
        logic               w_tok;
        logic               w_at_end;

        assign w_cfg_hit        = w_cfg_valid && (cfg_ch == CH_W'(gi));
        // A token arriving with a config write to its own channel is discarded.
        assign w_tok            = tok_in[gi] && !w_cfg_hit;
        assign w_at_end         = (r_ratio <= RATIO_W'(1)) || (r_cnt == r_ratio - RATIO_W'(1));
        assign w_pass[gi]       = w_tok && w_at_end;
        assign w_grant_vec[gi]  = w_any && w_slot_free && (w_grant == CH_W'(gi));
        assign w_pend[gi]       = r_pend;
        assign ovf[gi]          = r_ovf;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_ratio <= RATIO_W'(RATIO_DEFAULT);
                r_cnt   <= '0;
                r_pend  <= 1'b0;
                r_ovf   <= 1'b0;
            end else begin
                if (w_cfg_hit) begin
                    r_ratio <= cfg_ratio;
                    r_cnt   <= '0;
                    r_ovf   <= 1'b0;
                end else if (w_tok) begin
                    r_cnt <= w_at_end ? '0 : r_cnt + RATIO_W'(1);
                end
                if (w_pass[gi] && r_pend && !w_grant_vec[gi]) begin
                    r_ovf <= 1'b1;
                end
                r_pend <= (r_pend && !w_grant_vec[gi]) || w_pass[gi];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            r_ptr     <= '0;
        end else if (w_slot_free) begin
            if (w_any) begin
                out_valid <= 1'b1;
                out_ch    <= w_grant;
                r_ptr     <= (32'(w_grant) == N_CH - 1) ? '0 : w_grant + CH_W'(1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_token_decimate_scheduler.sv
// Scoreboard bench: stimulus pushes expected (channel, edge) pairs, a negedge
// monitor pops one per accepted output and flags any extra output.
module tb_token_decimate_scheduler;
    import token_sched_pkg::*;

    localparam int unsigned N = 4;

    typedef struct {
        int ch;
        int at;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   tok_in;
    logic           cfg_we;
    ch_idx_t        cfg_ch;
    ratio_t         cfg_ratio;
    logic           out_valid;
    ch_idx_t        out_ch;
    logic           out_ready;
    logic [N-1:0]   ovf;

    int   vectors     = 0;
    int   miscompares = 0;
    int   edge_n      = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    token_decimate_scheduler #(
        .N_CH    (N),
        .RATIO_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tok_in    (tok_in),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_ratio (cfg_ratio),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_ready (out_ready),
        .ovf       (ovf)
    );

    // at < 0 means the acceptance time is not checked, only the channel.
    always @(negedge clk) begin
        exp_t x;
        if (out_valid && out_ready) begin
            vectors++;
            if (sbq.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_output: got ch %0d at edge %0d, expected no output", out_ch, edge_n);
            end else begin
                x = sbq.pop_front();
                if (int'(out_ch) != x.ch || (x.at >= 0 && x.at != edge_n)) begin
                    miscompares++;
                    $display("FAIL output: got ch %0d at edge %0d, expected ch %0d at edge %0d",
                             out_ch, edge_n, x.ch, x.at);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic expect_out(input int ch, input int at);
        exp_t x;
        x.ch = ch;
        x.at = at;
        sbq.push_back(x);
    endtask

    // Drives one cycle of inputs; e returns the edge number that sampled them.
    task automatic cyc(input logic [N-1:0] t, input logic we, input int cch, input int cr, output int e);
        tok_in    = t;
        cfg_we    = we;
        cfg_ch    = ch_idx_t'(cch);
        cfg_ratio = ratio_t'(cr);
        @(posedge clk);
        #1;
        e      = edge_n;
        tok_in = '0;
        cfg_we = 1'b0;
    endtask

    task automatic tok(input logic [N-1:0] t, output int e);
        cyc(t, 1'b0, 0, 0, e);
    endtask

    task automatic cfg(input int ch, input int r);
        int e;
        cyc('0, 1'b1, ch, r, e);
    endtask

    task automatic idle(input int n);
        int e;
        for (int i = 0; i < n; i++) cyc('0, 1'b0, 0, 0, e);
    endtask

    initial begin
        int e;
        rst_n     = 1'b0;
        tok_in    = '0;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_ratio = '0;
        out_ready = 1'b1;
        idle(2);
        check("reset_valid", int'(out_valid), 0);
        check("reset_ch", int'(out_ch), 0);
        check("reset_ovf", int'(ovf), 0);
        rst_n = 1'b1;

        // Default ratio 2 on ch1: 2nd and 4th tokens pass.
        tok(4'b0010, e);
        tok(4'b0010, e); expect_out(1, e + 1);
        tok(4'b0010, e);
        tok(4'b0010, e); expect_out(1, e + 1);
        idle(4);
        check("t1_ovf", int'(ovf), 0);

        // Ratio 3 on ch0: 3rd, 6th, 9th tokens pass.
        cfg(0, 3);
        for (int i = 1; i <= 9; i++) begin
            tok(4'b0001, e);
            if (i % 3 == 0) expect_out(0, e + 1);
        end
        idle(4);

        // Ratio 1 everywhere, fresh pointer: two bursts each drain 0,1,2,3.
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) cfg(c, 1);
        tok(4'b1111, e);
        for (int k = 0; k < 4; k++) expect_out(k, e + 1 + k);
        idle(5);
        tok(4'b1111, e);
        for (int k = 0; k < 4; k++) expect_out(k, e + 1 + k);
        idle(5);
        check("t3_ovf", int'(ovf), 0);

        // Stalled output on ch2: held token, then a pending one, then overflow.
        out_ready = 1'b0;
        tok(4'b0100, e); expect_out(2, -1);
        idle(1);
        check("t4_hold_valid", int'(out_valid), 1);
        check("t4_hold_ch", int'(out_ch), 2);
        tok(4'b0100, e); expect_out(2, -1);
        check("t4_pend_no_ovf", int'(ovf), 0);
        tok(4'b0100, e);
        check("t4_ovf_set", int'(ovf), 4);
        check("t4_ovf_valid", int'(out_valid), 1);
        cfg(2, 1);
        check("t4_cfg_clr_ovf", int'(ovf), 0);
        check("t4_cfg_valid", int'(out_valid), 1);
        check("t4_cfg_ch", int'(out_ch), 2);
        out_ready = 1'b1;
        idle(4);

        // Token coinciding with config write on ch0 is ignored.
        cfg(0, 2);
        cyc(4'b0001, 1'b1, 0, 2, e);
        tok(4'b0001, e);
        tok(4'b0001, e); expect_out(0, e + 1);
        idle(4);

        // Reset while a token is held and ch3 has overflowed.
        out_ready = 1'b0;
        tok(4'b1010, e);
        tok(4'b1000, e);
        check("t6_pre_valid", int'(out_valid), 1);
        check("t6_pre_ch", int'(out_ch), 1);
        check("t6_pre_ovf", int'(ovf), 8);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        check("t6_rst_valid", int'(out_valid), 0);
        check("t6_rst_ch", int'(out_ch), 0);
        check("t6_rst_ovf", int'(ovf), 0);
        out_ready = 1'b1;
        idle(3);
        tok(4'b0010, e);
        tok(4'b0010, e); expect_out(1, e + 1);
        idle(4);

        check("scoreboard_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
